// File: rtl/lane_deskew_ctrl_if.sv
// rtl/lane_deskew_ctrl_if.sv - control/status bundle between the PCS AM lock lanes and the deskew controller
interface lane_deskew_ctrl_if #(
    parameter int N_LANES  = 20,
    parameter int NB_DELAY = 5
);
    logic                         i_enable;
    logic                         i_valid;
    logic [N_LANES-1:0]           i_am_lock;
    logic [N_LANES-1:0]           i_start_of_lane;
    logic [N_LANES*NB_DELAY-1:0]  o_lane_delay;
    logic                         o_deskew_done;
    logic [N_LANES-1:0]           o_resync;
    logic                         o_skew_error;

    modport master (
        output i_enable, i_valid, i_am_lock, i_start_of_lane,
        input  o_lane_delay, o_deskew_done, o_resync, o_skew_error
    );

    modport slave (
        input  i_enable, i_valid, i_am_lock, i_start_of_lane,
        output o_lane_delay, o_deskew_done, o_resync, o_skew_error
    );
endinterface

// File: rtl/lane_deskew_ctrl.sv
// rtl/lane_deskew_ctrl.sv - measures inter-lane AM skew and produces per-lane deskew read delays
module lane_deskew_ctrl #(
    parameter int N_LANES  = 20,
    parameter int MAX_SKEW = 16,
    parameter int NB_DELAY = $clog2(MAX_SKEW + 1)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    lane_deskew_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_MEASURE   = 3'd2;
    localparam logic [2:0] ST_ALIGNED   = 3'd3;
    localparam logic [2:0] ST_RESYNC    = 3'd4;

    localparam logic [NB_DELAY-1:0] CNT_LAST = NB_DELAY'(MAX_SKEW - 1);
    localparam logic [NB_DELAY-1:0] CNT_SAT  = NB_DELAY'(MAX_SKEW);

    logic [2:0]                           state_q, state_d;
    logic [NB_DELAY-1:0]                  cnt_q, cnt_d;
    logic [N_LANES-1:0]                   arrived_q, arrived_d;
    logic [N_LANES-1:0][NB_DELAY-1:0]     arrival_q, arrival_d;
    logic [N_LANES*NB_DELAY-1:0]          delay_q, delay_d;
    logic                                 done_q, done_d;
    logic [N_LANES-1:0]                   resync_q, resync_d;
    logic                                 skew_err_q, skew_err_d;
    logic                                 all_locked;
    logic [N_LANES-1:0]                   first_pulse;

    assign all_locked  = &bus.i_am_lock;
    assign first_pulse = bus.i_start_of_lane & ~arrived_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        arrived_d  = arrived_q;
        arrival_d  = arrival_q;
        delay_d    = delay_q;
        done_d     = done_q;
        resync_d   = '0;
        skew_err_d = 1'b0;

        if (!bus.i_enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            arrived_d = '0;
            arrival_d = '0;
            delay_d   = '0;
            done_d    = 1'b0;
        end else if (bus.i_valid) begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    cnt_d     = '0;
                    arrived_d = '0;
                    arrival_d = '0;
                    delay_d   = '0;
                    done_d    = 1'b0;
                    if (all_locked) state_d = ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (!all_locked) begin
                        state_d = ST_WAIT_LOCK;
                    end else if ((|arrived_q) || (|bus.i_start_of_lane)) begin
                        // cnt_q is the tick index relative to the first arrival
                        for (int k = 0; k < N_LANES; k++) begin
                            if (first_pulse[k]) arrival_d[k] = cnt_q;
                        end
                        arrived_d = arrived_q | bus.i_start_of_lane;
                        if (&arrived_d) begin
                            for (int k = 0; k < N_LANES; k++) begin
                                delay_d[k*NB_DELAY +: NB_DELAY] = cnt_q - arrival_d[k];
                            end
                            done_d  = 1'b1;
                            state_d = ST_ALIGNED;
                        end else if (cnt_q == CNT_LAST) begin
                            cnt_d      = CNT_SAT;
                            skew_err_d = 1'b1;
                            state_d    = ST_RESYNC;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_ALIGNED: begin
                    if (!all_locked) begin
                        delay_d = '0;
                        done_d  = 1'b0;
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_RESYNC: begin
                    resync_d = '1;
                    state_d  = ST_WAIT_LOCK;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            arrived_q  <= '0;
            arrival_q  <= '0;
            delay_q    <= '0;
            done_q     <= 1'b0;
            resync_q   <= '0;
            skew_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            arrived_q  <= arrived_d;
            arrival_q  <= arrival_d;
            delay_q    <= delay_d;
            done_q     <= done_d;
            resync_q   <= resync_d;
            skew_err_q <= skew_err_d;
        end
    end

    assign bus.o_lane_delay  = delay_q;
    assign bus.o_deskew_done = done_q;
    assign bus.o_resync      = resync_q;
    assign bus.o_skew_error  = skew_err_q;
endmodule

// File: doc/lane_deskew_ctrl.md
# lane_deskew_ctrl

Sequencing controller for the 20 per-lane AM lock instances on the 100GbE PCS receive path. It waits until every lane reports alignment-marker lock, then times the per-lane start-of-lane pulses to measure inter-lane skew. From that measurement it produces per-lane read delays for the deskew buffers and asserts deskew-done. It requests resync of all lanes when skew exceeds the tolerated window.

## Interface
- N_LANES, 20, number of PCS lanes / AM lock instances
- MAX_SKEW, 16, max tolerated arrival spread in valid cycles (window length)
- NB_DELAY, $clog2(MAX_SKEW+1) (=5), width of one lane delay / skew counter

- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  block enable; low forces IDLE synchronously
- i_valid  in  1  data-valid qualifier; all state/counter updates only when high
- i_am_lock  in  N_LANES  per-lane AM lock status (level)
- i_start_of_lane  in  N_LANES  per-lane single-cycle pulse at AM reception, qualified by i_valid
- o_lane_delay  out  N_LANES*NB_DELAY  lane k delay at bits [k*NB_DELAY +: NB_DELAY]
- o_deskew_done  out  1  deskew complete, delays valid (level)
- o_resync  out  N_LANES  per-lane resync request to AM lock instances (one-cycle pulse)
- o_skew_error  out  1  one-cycle pulse when window expires before all lanes arrive

## Operation
- Valid tick = i_enable & i_valid; the FSM, counter and arrival flags change only on a valid tick, except for reset and the i_enable=0 return.
- FSM states: IDLE, WAIT_LOCK, MEASURE, ALIGNED, RESYNC.
- IDLE: outputs cleared. Valid tick → WAIT_LOCK.
- WAIT_LOCK: when &i_am_lock → MEASURE. Arrival flags are cleared and skew counter = 0.
- MEASURE:
  - Counter idle until the first tick with any i_start_of_lane bit set. That tick is t=0; counter increments on every later valid tick.
  - A lane's first pulse records arrival[k] = current t and sets arrived[k]. Repeat pulses from an already-arrived lane are ignored.
  - Several lanes pulsing on the same tick record the same t.
  - All lanes arrived (including on the current tick) → delay[k] = t_last − arrival[k], where t_last = the arrival tick of the last lane. Then → ALIGNED.
  - Counter reaching MAX_SKEW with any lane missing → o_skew_error pulse, → RESYNC.
  - Any i_am_lock bit low → WAIT_LOCK.
- ALIGNED: o_deskew_done=1 and o_lane_delay held. Any i_am_lock bit low → WAIT_LOCK, which clears o_deskew_done and o_lane_delay.
- RESYNC: o_resync = all ones for exactly one valid tick, then → WAIT_LOCK.
- Arithmetic: unsigned, NB_DELAY bits. The counter saturates at MAX_SKEW and never wraps. Every delay lies in 0..MAX_SKEW−1.
- i_enable low on any cycle → IDLE next edge; all outputs 0.

## Timing
- Reset (i_reset=0, async): state IDLE, counter 0, arrival flags 0. All outputs are 0: o_lane_delay, o_deskew_done, o_resync and o_skew_error.
- All outputs are registered.
- o_lane_delay and o_deskew_done update on the edge after the valid tick on which the last lane arrives (latency 1).
- o_skew_error is high for 1 cycle, on the edge after the tick where the counter reaches MAX_SKEW. o_resync is high for the following cycle.
- Lock drop: o_deskew_done falls 1 cycle after the tick on which any i_am_lock bit is low.
- Reset asserted mid-MEASURE discards partial arrivals. After release, the block restarts from IDLE.
- Ticks with i_valid=0 freeze the counter and ignore pulses. Skew is therefore measured in valid ticks.

## Test plan
- All lanes locked, all 20 SOL bits set on one tick → o_deskew_done=1 next cycle, every delay = 0.
- Lane k pulses at tick (k mod 4) → done 1 cycle after tick 3; delay[k] = 3 − (k mod 4) (lane 0=3, lane 3=0).
- Lanes 0–18 pulse at t=0, lane 19 never pulses → o_skew_error pulse at count 16, o_resync = 20'hFFFFF for 1 cycle, then WAIT_LOCK.
- ALIGNED with i_am_lock[7] dropped for 1 tick → o_deskew_done=0 next cycle, delays cleared. After relock plus a new measurement, done reasserts.
- Staggered arrival with i_valid toggled 1/0 each cycle → delays equal the spread counted in valid ticks only. Duplicate SOL pulses are ignored.
- i_reset low while 10 lanes have arrived → all outputs 0 immediately. After release + enable, a full fresh measurement is required before done.
